// File: rtl/uart_irq_ctrl.sv
// uart_irq_ctrl -- APB-programmable interrupt controller for the UART.
//
// Captures 1-cycle event pulses from UART sources into sticky STATUS bits,
// masks them with ENABLE, reports the lowest-index pending source in ID and
// drives a single registered irq line.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   psel, penable,    APB slave: zero wait states (pready tied 1), pslverr
//   pwrite, paddr,      on access to an unmapped address, prdata is 0
//   pwdata, prdata,     outside a read access phase
//   pready, pslverr
//   src_evt[NSRC]     event pulses, bit i = source i
//   irq               registered interrupt request
//
// Register map (byte address, paddr[1:0] ignored):
//   0x00 STATUS  RW1C   0x04 ENABLE RW   0x08 PENDING RO   0x0C ID RO
//   0x10 HOLDOFF RW (only when UART_IRQ_COALESCE_EN is defined)
//
// Build option: define UART_IRQ_COALESCE_EN to add the HOLDOFF register and
// the HOLD state, which keeps irq low for HOLDOFF cycles after it falls.
//
// state  | meaning
// IDLE   | irq low, waiting for an enabled pending source
// ASSERT | irq high while any enabled source is pending
// HOLD   | irq held low for the holdoff window (coalescing builds only)

module uart_irq_ctrl #(
   parameter int NSRC   = 8,
   parameter int HOLD_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            psel,
   input  logic            penable,
   input  logic            pwrite,
   input  logic [4:0]      paddr,
   input  logic [31:0]     pwdata,
   output logic [31:0]     prdata,
   output logic            pready,
   output logic            pslverr,
   input  logic [NSRC-1:0] src_evt,
   output logic            irq
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      HOLD   = 2'd2
   } state_t;

   localparam logic [2:0] A_STATUS  = 3'd0;
   localparam logic [2:0] A_ENABLE  = 3'd1;
   localparam logic [2:0] A_PENDING = 3'd2;
   localparam logic [2:0] A_ID      = 3'd3;
   localparam logic [2:0] A_HOLDOFF = 3'd4;

   logic [2:0]      addr;
   logic            access;
   logic            wr_en;
   logic            mapped;
   logic [NSRC-1:0] status;
   logic [NSRC-1:0] enable;
   logic [NSRC-1:0] pending;
   logic [NSRC-1:0] w1c;
   logic            pend;
   logic [4:0]      id;
   state_t          state;
   logic            unused;

`ifdef UART_IRQ_COALESCE_EN
   logic [HOLD_W-1:0] holdoff;
   logic [HOLD_W-1:0] cnt;
`endif

   assign addr    = paddr[4:2];
   assign access  = psel & penable;
   assign wr_en   = access & pwrite;
   assign pending = status & enable;
   assign pend    = |pending;
   assign pready  = 1'b1;
   assign w1c     = (wr_en && addr == A_STATUS) ? pwdata[NSRC-1:0] : '0;
   assign unused  = ^{paddr[1:0], pwdata};

   always_comb begin
      case (addr)
         A_STATUS, A_ENABLE, A_PENDING, A_ID: mapped = 1'b1;
`ifdef UART_IRQ_COALESCE_EN
         A_HOLDOFF: mapped = 1'b1;
`endif
         default: mapped = 1'b0;
      endcase
   end

   assign pslverr = access & ~mapped;

   // Descending scan so the lowest pending index is the one left in id.
   always_comb begin
      id = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (pending[i]) id = 5'(i);
      end
   end

   always_comb begin
      prdata = '0;
      if (access && !pwrite) begin
         case (addr)
            A_STATUS:  prdata[NSRC-1:0] = status;
            A_ENABLE:  prdata[NSRC-1:0] = enable;
            A_PENDING: prdata[NSRC-1:0] = pending;
            A_ID: begin
               prdata[31]  = pend;
               prdata[4:0] = id;
            end
`ifdef UART_IRQ_COALESCE_EN
            A_HOLDOFF: prdata[HOLD_W-1:0] = holdoff;
`endif
            default: prdata = '0;
         endcase
      end
   end

   // A new event wins over a simultaneous W1C of the same bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status <= '0;
         enable <= '0;
      end else begin
         status <= (status & ~w1c) | src_evt;
         if (wr_en && addr == A_ENABLE) enable <= pwdata[NSRC-1:0];
      end
   end

`ifdef UART_IRQ_COALESCE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         holdoff <= '0;
      end else if (wr_en && addr == A_HOLDOFF) begin
         holdoff <= pwdata[HOLD_W-1:0];
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         irq   <= 1'b0;
`ifdef UART_IRQ_COALESCE_EN
         cnt   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pend) begin
                  state <= ASSERT;
                  irq   <= 1'b1;
               end
            end
            ASSERT: begin
               if (!pend) begin
                  irq <= 1'b0;
`ifdef UART_IRQ_COALESCE_EN
                  if (holdoff != '0) begin
                     state <= HOLD;
                     cnt   <= holdoff;
                  end else begin
                     state <= IDLE;
                  end
`else
                  state <= IDLE;
`endif
               end
            end
`ifdef UART_IRQ_COALESCE_EN
            // The count is latched on entry, so HOLDOFF writes here only
            // affect the next window. Leaving as cnt steps down to 1 lets
            // the IDLE evaluation cycle be the last low cycle, so irq stays
            // low for exactly HOLDOFF cycles.
            HOLD: begin
               cnt <= cnt - HOLD_W'(1);
               if (cnt <= HOLD_W'(2)) state <= IDLE;
            end
`endif
            default: begin
               state <= IDLE;
               irq   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_irq_ctrl.sv
module tb_uart_irq_ctrl;

   localparam int NSRC   = 8;
   localparam int HOLD_W = 16;

`ifdef UART_IRQ_COALESCE_EN
   localparam bit COAL = 1'b1;
`else
   localparam bit COAL = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            psel;
   logic            penable;
   logic            pwrite;
   logic [4:0]      paddr;
   logic [31:0]     pwdata;
   logic [31:0]     prdata;
   logic            pready;
   logic            pslverr;
   logic [NSRC-1:0] src_evt;
   logic            irq;

   always #5 clk = ~clk;

   uart_irq_ctrl #(.NSRC(NSRC), .HOLD_W(HOLD_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .prdata  (prdata),
      .pready  (pready),
      .pslverr (pslverr),
      .src_evt (src_evt),
      .irq     (irq)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // irq rises one edge after an enabled source is pending; after it falls
   // pend is ignored for HOLDOFF-1 further edges (coalescing only).
   logic [NSRC-1:0]   m_status;
   logic [NSRC-1:0]   m_enable;
   logic [HOLD_W-1:0] m_hold;
   bit                m_irq;
   int                m_block;
   bit                m_live = 1'b0;

   always @(posedge clk or posedge rst) begin : mdl
      bit              pend_now;
      logic [NSRC-1:0] clr;
      logic [2:0]      a;
      if (rst) begin
         m_status = '0;
         m_enable = '0;
         m_hold   = '0;
         m_irq    = 1'b0;
         m_block  = 0;
      end else begin
         pend_now = |(m_status & m_enable);
         if (m_irq) begin
            if (!pend_now) begin
               m_irq   = 1'b0;
               m_block = (COAL && m_hold != 0) ? int'(m_hold) - 1 : 0;
            end
         end else if (m_block > 0) begin
            m_block--;
         end else if (pend_now) begin
            m_irq = 1'b1;
         end
         clr = '0;
         a   = paddr[4:2];
         if (psel && penable && pwrite) begin
            if (a == 3'd0) clr = pwdata[NSRC-1:0];
            else if (a == 3'd1) m_enable = pwdata[NSRC-1:0];
            else if (a == 3'd4 && COAL) m_hold = pwdata[HOLD_W-1:0];
         end
         m_status = (m_status & ~clr) | src_evt;
      end
   end

   function automatic logic [31:0] exp_read(input logic [4:0] ad);
      logic [31:0]     r;
      logic [NSRC-1:0] p;
      r = '0;
      p = m_status & m_enable;
      case (ad[4:2])
         3'd0: r[NSRC-1:0] = m_status;
         3'd1: r[NSRC-1:0] = m_enable;
         3'd2: r[NSRC-1:0] = p;
         3'd3: begin
            for (int i = 0; i < NSRC; i++) begin
               if (p[i]) begin
                  r[31]  = 1'b1;
                  r[4:0] = 5'(i);
                  break;
               end
            end
         end
         3'd4: if (COAL) r[HOLD_W-1:0] = m_hold;
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic exp_err(input logic [4:0] ad);
      return (ad[4:2] > 3'd3) && !(ad[4:2] == 3'd4 && COAL);
   endfunction

   // Every-cycle irq comparison against the model.
   always @(negedge clk) begin
      if (m_live && !rst) check("irq_vs_model", {31'b0, irq}, {31'b0, m_irq});
   end

   // Length of the most recent completed low stretch of irq.
   int run_len  = 0;
   int last_run = 0;
   always @(negedge clk) begin
      if (rst) run_len = 0;
      else if (!irq) run_len++;
      else if (run_len > 0) begin
         last_run = run_len;
         run_len  = 0;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic apb_read(input logic [4:0] ad, output logic [31:0] data, output logic err);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = ad;
      @(negedge clk);
      check("prdata_setup_zero", prdata, 32'h0);
      step();
      penable = 1'b1;
      @(negedge clk);
      data = prdata;
      err  = pslverr;
      check("read_vs_model", data, exp_read(ad));
      check("pslverr_read", {31'b0, err}, {31'b0, exp_err(ad)});
      step();
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic apb_write(input logic [4:0] ad, input logic [31:0] wd, input logic [NSRC-1:0] evt);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = ad; pwdata = wd;
      step();
      penable = 1'b1;
      src_evt = evt;
      @(negedge clk);
      check("pslverr_write", {31'b0, pslverr}, {31'b0, exp_err(ad)});
      step();
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; src_evt = '0;
   endtask

   task automatic pulse(input logic [NSRC-1:0] mask);
      src_evt = mask;
      step();
      src_evt = '0;
   endtask

   task automatic wait_irq(input logic lvl, input int max_cyc, input string name);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < max_cyc && !hit; i++) begin
         @(negedge clk);
         if (irq === lvl) hit = 1'b1;
      end
      #1;
      check(name, {31'b0, irq}, {31'b0, lvl});
      @(posedge clk);
      #2;
   endtask

   task automatic check_irq_at_negedge(input string name, input logic lvl);
      @(negedge clk);
      check(name, {31'b0, irq}, {31'b0, lvl});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic        e;

      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; src_evt = '0;
      repeat (2) @(posedge clk);
      #2;
      rst    = 1'b0;
      m_live = 1'b1;

      // reset state
      for (int a = 0; a < (COAL ? 5 : 4); a++) begin
         apb_read(5'(a * 4), d, e);
         check("reset_reg_zero", d, 32'h0);
         check("reset_pslverr", {31'b0, e}, 32'h0);
      end
      check("reset_irq", {31'b0, irq}, 32'h0);
      check("pready_high", {31'b0, pready}, 32'h1);

      // single source: latency of raise and clear
      apb_write(5'h04, 32'h1, '0);
      pulse(8'h01);
      check_irq_at_negedge("irq_after_edge_n", 1'b0);
      check_irq_at_negedge("irq_after_edge_n1", 1'b1);
      apb_read(5'h00, d, e);  check("status_src0", d, 32'h1);
      apb_read(5'h08, d, e);  check("pending_src0", d, 32'h1);
      apb_read(5'h0C, d, e);  check("id_src0", d, 32'h8000_0000);
      apb_write(5'h00, 32'h1, '0);
      check_irq_at_negedge("irq_after_w1c_m", 1'b1);
      check_irq_at_negedge("irq_after_w1c_m1", 1'b0);

      // priority encoding
      apb_write(5'h04, 32'hFF, '0);
      pulse(8'h24);
      apb_read(5'h0C, d, e);  check("id_src2", d, 32'h8000_0002);
      apb_write(5'h00, 32'h04, '0);
      apb_read(5'h0C, d, e);  check("id_src5", d, 32'h8000_0005);
      check("irq_stays_high", {31'b0, irq}, 32'h1);

      // set wins over simultaneous W1C
      apb_write(5'h00, 32'h08, 8'h08);
      apb_read(5'h00, d, e);  check("status_set_wins", d, 32'h28);
      apb_write(5'h00, 32'hFF, '0);
      repeat (3) step();
      check("irq_low_after_clear", {31'b0, irq}, 32'h0);

      // disabled source stays sticky, enabling it raises irq one edge later
      apb_write(5'h04, 32'h0, '0);
      pulse(8'h02);
      repeat (3) step();
      check("irq_masked", {31'b0, irq}, 32'h0);
      apb_read(5'h00, d, e);  check("status_masked_src1", d, 32'h02);
      apb_write(5'h04, 32'h02, '0);
      check_irq_at_negedge("irq_enable_edge_m", 1'b0);
      check_irq_at_negedge("irq_enable_edge_m1", 1'b1);

      // RO and unmapped accesses
      apb_write(5'h0C, 32'hFF, '0);
      apb_write(5'h08, 32'hFF, '0);
      apb_read(5'h04, d, e);  check("enable_after_ro_write", d, 32'h02);
      apb_read(5'h0C, d, e);  check("id_src1", d, 32'h8000_0001);
      apb_read(5'h1C, d, e);
      check("unmapped_data", d, 32'h0);
      check("unmapped_err", {31'b0, e}, 32'h1);
      apb_write(5'h00, 32'hFFFF_FFFF, '0);
      apb_read(5'h00, d, e);  check("status_upper_ignored", d, 32'h0);

      // clear, then re-pulse right after the clear
      apb_write(5'h04, 32'h01, '0);
`ifdef UART_IRQ_COALESCE_EN
      apb_write(5'h10, 32'h4, '0);
      apb_read(5'h10, d, e);  check("holdoff_readback", d, 32'h4);
      pulse(8'h01);
      wait_irq(1'b1, 10, "irq_rise_before_hold");
      apb_write(5'h00, 32'h1, '0);
      apb_write(5'h04, 32'h1, 8'h01);
      wait_irq(1'b1, 20, "irq_rise_after_hold4");
      check("hold4_low_cycles", last_run, 32'd4);

      // HOLDOFF rewritten during HOLD: running window unchanged
      apb_write(5'h00, 32'h1, '0);
      apb_write(5'h10, 32'h2, 8'h01);
      wait_irq(1'b1, 20, "irq_rise_after_hold_rewrite");
      check("hold_rewrite_low_cycles", last_run, 32'd4);

      // new value used for the next window
      apb_write(5'h00, 32'h1, '0);
      apb_write(5'h04, 32'h1, 8'h01);
      wait_irq(1'b1, 20, "irq_rise_after_hold2");
      check("hold2_low_cycles", last_run, 32'd2);
`else
      apb_read(5'h10, d, e);
      check("holdoff_absent_data", d, 32'h0);
      check("holdoff_absent_err", {31'b0, e}, 32'h1);
      apb_write(5'h10, 32'h4, '0);
      pulse(8'h01);
      wait_irq(1'b1, 10, "irq_rise_before_clear");
      apb_write(5'h00, 32'h1, '0);
      apb_write(5'h04, 32'h1, 8'h01);
      wait_irq(1'b1, 20, "irq_rise_after_repulse");
      check("no_hold_low_cycles", last_run, 32'd2);
`endif

      // reset mid-operation
      check("irq_high_before_reset", {31'b0, irq}, 32'h1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("irq_cleared_by_reset", {31'b0, irq}, 32'h0);
      step();
      rst = 1'b0;
      apb_read(5'h00, d, e);  check("status_after_reset", d, 32'h0);
      apb_read(5'h04, d, e);  check("enable_after_reset", d, 32'h0);
`ifdef UART_IRQ_COALESCE_EN
      apb_read(5'h10, d, e);  check("holdoff_after_reset", d, 32'h0);
`endif
      check("irq_after_reset", {31'b0, irq}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
